bram_stream_reader: RTL and testbench



---
 rtl/bram_stream_reader_pkg.sv | 25 ++
 rtl/bram_stream_reader_stream_fifo2.sv | 67 ++++++
 rtl/bram_stream_reader.sv | 101 ++++++++++
 tb/tb_bram_stream_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : bram_stream_reader_pkg                                       |
// | Description : Shared state encodings, buffer depth and credit check for    |
// |               the block RAM stream reader.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package bram_stream_reader_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    localparam int c_BUF_DEPTH = 2;

    // A read may issue only if every word already owed to the buffer still fits.
    function automatic logic credit_ok(input logic [1:0] occ, input logic inflight,
                                       input logic pop);
        credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'(c_BUF_DEPTH) + {2'b00, pop});
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_stream_reader_stream_fifo2.sv
// +----------------------------------------------------------------------------+
// | Module      : stream_fifo2                                                 |
// | Description : Two-entry registered FIFO; entry 0 is always the head.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_fifo2
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_e0;
    logic [WIDTH-1:0] r_e1;
    logic [1:0]       r_occ;
    logic             w_pop;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign o_head = r_e0;
    assign o_occ  = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_occ <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ != 2'(c_BUF_DEPTH)) begin
                        if (r_occ == 2'd0) r_e0 <= i_din;
                        else               r_e1 <= i_din;
                        r_occ <= r_occ + 2'd1;
                    end
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'(c_BUF_DEPTH)) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_din;
                    end else begin
                        r_e0 <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !w_pop && (r_occ == 2'(c_BUF_DEPTH))));

endmodule

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// +----------------------------------------------------------------------------+
// | Module      : bram_stream_reader                                           |
// | Description : Walks a wrap-around RAM address range and streams the read   |
// |               data out with credit-limited issue into a 2-entry buffer.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_en,
    output logic [ADDR_SIZE-1:0] bram_r_addr,
    input  logic [WORD_SIZE-1:0] bram_dout,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam logic [ADDR_SIZE:0] c_ONE = 1;

    logic [1:0]           r_state;
    logic [ADDR_SIZE-1:0] r_base;
    logic [ADDR_SIZE:0]   r_count;
    logic [ADDR_SIZE:0]   r_issued;
    logic [ADDR_SIZE:0]   r_popped;
    logic                 r_inflight;

    logic                 w_run;
    logic                 w_pop;
    logic                 w_en;
    logic [1:0]           w_occ;

    assign w_run   = (r_state == c_RUN);
    assign m_valid = (w_occ != 2'd0);
    assign w_pop   = m_valid && m_ready;

    // The pop is counted in the same cycle, so issue resumes as soon as ready rises.
    assign w_en = w_run && (r_issued < r_count) && credit_ok(w_occ, r_inflight, w_pop);

    assign bram_en     = w_en;
    assign bram_r_addr = r_base + r_issued[ADDR_SIZE-1:0];
    assign busy        = (r_state != c_IDLE);
    assign done        = (r_state == c_FLUSH) || (w_run && (r_popped == r_count));

    stream_fifo2 #(
        .WIDTH (WORD_SIZE)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_din  (bram_dout),
        .i_pop  (w_pop),
        .o_head (m_data),
        .o_occ  (w_occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_en;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_base   <= base_addr;
                        r_count  <= count;
                        r_issued <= '0;
                        r_popped <= '0;
                        r_state  <= (count == '0) ? c_FLUSH : c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_en)  r_issued <= r_issued + c_ONE;
                    if (w_pop) r_popped <= r_popped + c_ONE;
                    if (r_popped == r_count) r_state <= c_IDLE;
                end
                c_FLUSH: r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_bram_stream_reader                                        |
// | Description : Directed self-checking bench for bram_stream_reader.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bram_stream_reader;

    localparam int WS = 32;
    localparam int AS = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AS-1:0] base_addr = '0;
    logic [AS:0]   count = '0;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [AS-1:0] bram_r_addr;
    logic [WS-1:0] bram_dout = '0;
    logic [WS-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;

    logic [WS-1:0] mem [64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int pop_cnt = 0;
    int max_out = 0;
    logic [WS-1:0] got_q [$];
    logic [AS-1:0] addr_q [$];

    always #5 clk = ~clk;

    // Registered-read RAM model; content is 0xA000_0000 + address.
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_r_addr];

    bram_stream_reader #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .bram_en     (bram_en),
        .bram_r_addr (bram_r_addr),
        .bram_dout   (bram_dout),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                pop_cnt++;
            end
            if (bram_en) begin
                addr_q.push_back(bram_r_addr);
                en_cnt++;
            end
            if (done) done_cnt++;
            if (en_cnt - pop_cnt > max_out) max_out = en_cnt - pop_cnt;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AS-1:0] b, input logic [AS:0] c);
        @(negedge clk);
        #2;
        start = 1'b1;
        base_addr = b;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        got_q.delete();
        addr_q.delete();
        done_cnt = 0;
        en_cnt = 0;
        pop_cnt = 0;
        max_out = 0;
        cyc = 0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: done_cnt=%0d after %0d cycles, required >=1", name, done_cnt, n);
        end
        tick();
        tick();
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy, done, bram_en, m_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: {busy,done,en,valid}=%b required 0000", {busy, done, bram_en, m_valid});
        end
        checks++;
        if (bram_r_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d required 0", bram_r_addr);
        end
        checks++;
        if (m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", m_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [WS-1:0] exp;
        m_ready = 1'b1;
        do_start(6'd5, 7'd4);
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (n == 1) begin
                if ({busy, bram_en, bram_r_addr} !== {1'b1, 1'b1, 6'd5}) begin
                    errors++;
                    $display("FAIL basic_c1: busy=%b en=%b addr=%0d required 1 1 5", busy, bram_en, bram_r_addr);
                end
            end else if (n == 2) begin
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_latency: m_valid=%b in cycle 2 required 0", m_valid);
                end
            end else if (n <= 6) begin
                exp = 32'hA000_0000 + 32'(n + 2);
                if ({m_valid, m_data} !== {1'b1, exp}) begin
                    errors++;
                    $display("FAIL basic_data_c%0d: valid=%b data=%h required 1 %h", n, m_valid, m_data, exp);
                end
            end else if (n == 7) begin
                if ({done, busy, m_valid} !== 3'b110) begin
                    errors++;
                    $display("FAIL basic_done: {done,busy,valid}=%b required 110", {done, busy, m_valid});
                end
            end else begin
                if ({done, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL basic_idle: {done,busy}=%b required 00", {done, busy});
                end
            end
        end
    endtask

    task automatic test_wrap;
        int exp_a [4] = '{62, 63, 0, 1};
        logic [WS-1:0] exp_d;
        m_ready = 1'b1;
        do_start(6'd62, 7'd4);
        wait_done(20, "wrap");
        checks++;
        if (addr_q.size() != 4 || got_q.size() != 4) begin
            errors++;
            $display("FAIL wrap_len: addrs=%0d words=%0d required 4 4", addr_q.size(), got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_d = 32'hA000_0000 + 32'(exp_a[i]);
                checks++;
                if (addr_q[i] !== 6'(exp_a[i]) || got_q[i] !== exp_d) begin
                    errors++;
                    $display("FAIL wrap_%0d: addr=%0d data=%h required %0d %h", i, addr_q[i], got_q[i], exp_a[i], exp_d);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int rdy [16] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1};
        logic [WS-1:0] exp_d;
        do_start(6'd20, 7'd8);
        for (int i = 0; i < 16; i++) begin
            m_ready = rdy[i][0];
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        wait_done(40, "bp");
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL bp_len: words=%0d required 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_d = 32'hA000_0000 + 32'(20 + i);
                checks++;
                if (got_q[i] !== exp_d) begin
                    errors++;
                    $display("FAIL bp_data_%0d: got %h required %h", i, got_q[i], exp_d);
                end
            end
        end
        checks++;
        if (max_out != 2) begin
            errors++;
            $display("FAIL bp_outstanding: max outstanding=%0d required 2", max_out);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL bp_done_once: done pulses=%0d required 1", done_cnt);
        end
    endtask

    task automatic test_count0;
        m_ready = 1'b1;
        do_start(6'd7, 7'd0);
        tick();
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL cnt0_c1: {done,busy}=%b required 11", {done, busy});
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00 || en_cnt != 0) begin
            errors++;
            $display("FAIL cnt0_c2: {done,busy}=%b en_pulses=%0d required 00 0", {done, busy}, en_cnt);
        end
    endtask

    task automatic test_count64;
        logic [WS-1:0] exp_d;
        m_ready = 1'b1;
        do_start(6'd17, 7'd64);
        wait_done(100, "c64");
        checks++;
        if (got_q.size() != 64) begin
            errors++;
            $display("FAIL c64_len: words=%0d required 64", got_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                exp_d = 32'hA000_0000 + 32'((17 + i) % 64);
                checks++;
                if (got_q[i] !== exp_d) begin
                    errors++;
                    $display("FAIL c64_data_%0d: got %h required %h", i, got_q[i], exp_d);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL c64_done_once: done pulses=%0d required 1", done_cnt);
        end
    endtask

    task automatic test_start_busy;
        logic [WS-1:0] exp_d;
        m_ready = 1'b1;
        do_start(6'd3, 7'd4);
        tick();
        tick();
        start = 1'b1;
        base_addr = 6'd0;
        count = 7'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(20, "busy_start");
        checks++;
        if (got_q.size() != 4 || addr_q.size() != 4) begin
            errors++;
            $display("FAIL sb_len: words=%0d addrs=%0d required 4 4", got_q.size(), addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_d = 32'hA000_0000 + 32'(3 + i);
                checks++;
                if (got_q[i] !== exp_d) begin
                    errors++;
                    $display("FAIL sb_data_%0d: got %h required %h", i, got_q[i], exp_d);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL sb_done_once: done pulses=%0d required 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        m_ready = 1'b1;
        do_start(6'd40, 7'd8);
        tick();
        tick();
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bram_en, m_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_ctrl: {busy,done,en,valid}=%b required 0000", {busy, done, bram_en, m_valid});
        end
        checks++;
        if (bram_r_addr !== 6'd0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_bus: addr=%0d data=%h required 0 0", bram_r_addr, m_data);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nodone: done pulses=%0d busy=%b required 0 0", done_cnt, busy);
        end
        do_start(6'd10, 7'd2);
        wait_done(20, "rstmid");
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL rstmid_len: words=%0d required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'hA000_000A || got_q[1] !== 32'hA000_000B) begin
                errors++;
                $display("FAIL rstmid_data: got %h %h required a000000a a000000b", got_q[0], got_q[1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_count0();
        test_count64();
        test_start_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
